// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo write port among NUM_REQ
// producers; bursts hold the grant for up to MAX_BURST beats.
//
// Ports:
//   clk_i, rstn_i   clock, async active-low reset
//   req_i, data_i,  per-requester beat valid, packed data,
//   last_i          and last-beat-of-burst flag
//   gnt_o           one-hot-or-zero accept strobe
//   fifo_din_o,     fifo write data / enable
//   fifo_we_o
//   fifo_full_i     fifo full backpressure
//   owner_o         current/last burst owner
//   busy_o          a burst is in progress
module fifo_wr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*WIDTH-1:0]   data_i,
  input  logic [NUM_REQ-1:0]         last_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [WIDTH-1:0]           fifo_din_o,
  output logic                       fifo_we_o,
  input  logic                       fifo_full_i,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       busy_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] beat_cnt;

  logic [PW-1:0] win;
  logic          any_req;
  logic [PW-1:0] sel;
  logic          xfer;
  int            idx;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    // modulo wrap, NUM_REQ need not be a power of two
    if (p == PW'(NUM_REQ - 1)) return '0;
    return p + 1'b1;
  endfunction

  // rotating priority search from ptr
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        win     = PW'(idx);
      end
    end
  end

  // gated by rstn_i so grants drop at once on reset
  always_comb begin
    gnt_o = '0;
    sel   = (state == BURST) ? owner : win;
    if (rstn_i && !fifo_full_i) begin
      if (state == BURST)
        gnt_o[owner] = req_i[owner];
      else if (any_req)
        gnt_o[win] = 1'b1;
    end
  end

  assign xfer       = |(req_i & gnt_o);
  assign fifo_we_o  = xfer;
  assign fifo_din_o = xfer ?
    data_i[int'(sel)*WIDTH +: WIDTH] : '0;
  assign owner_o    = owner;
  assign busy_o     = (state == BURST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            owner <= win;
            if (last_i[win] || MAX_BURST == 1) begin
              ptr <= inc(win);
            end else begin
              state    <= BURST;
              beat_cnt <= CW'(1);
            end
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_i[owner] ||
                beat_cnt == CW'(MAX_BURST - 1)) begin
              state    <= IDLE;
              ptr      <= inc(owner);
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the write port of one `fifo` instance among NUM_REQ requesters.
- Each requester offers beats with a valid/accept handshake.
- The block drives the fifo's din/we and uses its full flag as backpressure.
- Multi-beat bursts hold the grant, so one requester's beats stay contiguous in the fifo, up to MAX_BURST beats.
- Sits between producer blocks and the fifo's din_i/we_i/F_o.

Parameters:
- WIDTH, 32, data width of each requester and of the fifo write port
- NUM_REQ, 4, number of requesters (>=2)
- MAX_BURST, 4, max beats per grant before forced re-arbitration (>=1)

Ports:
- clk_i  input  1  clock, rising edge
- rstn_i  input  1  asynchronous active-low reset
- req_i  input  NUM_REQ  per-requester beat valid
- data_i  input  NUM_REQ*WIDTH  packed beats; requester k occupies bits [k*WIDTH +: WIDTH]
- last_i  input  NUM_REQ  per-requester last-beat-of-burst flag, qualified by req_i
- gnt_o  output  NUM_REQ  one-hot-or-zero; beat of requester k is accepted this cycle when req_i[k] & gnt_o[k]
- fifo_din_o  output  WIDTH  to fifo din_i
- fifo_we_o  output  1  to fifo we_i
- fifo_full_i  input  1  from fifo F_o
- owner_o  output  $clog2(NUM_REQ)  current/last burst owner
- busy_o  output  1  high in BURST state

Behaviour:
- One clock; reset is asynchronous and active-low on rstn_i. Reset state: IDLE, prio pointer 0, owner_o 0, beat_cnt 0, busy_o 0, gnt_o 0, fifo_we_o 0, fifo_din_o 0.
- Zero-latency handshake: gnt_o, fifo_we_o and fifo_din_o are combinational from the current state and inputs.
  - fifo_we_o = |(req_i & gnt_o).
  - fifo_din_o = data of the granted requester when fifo_we_o=1, else 0.
- gnt_o is never asserted while fifo_full_i=1, and never to a requester with req_i=0.
- State IDLE:
  - Winner = first k with req_i[k]=1, searching pointer, pointer+1, ... NUM_REQ-1, then wrapping to 0.
  - If any req_i and fifo_full_i=0: gnt_o[winner]=1, beat written, owner_o<=winner.
  - If last_i[winner]=1 or MAX_BURST==1: stay IDLE; pointer <= winner+1 mod NUM_REQ.
  - Otherwise: go to BURST, beat_cnt<=1.
  - No req_i, or fifo_full_i=1: nothing granted; pointer unchanged.
- State BURST:
  - Only owner may transfer: gnt_o[owner]=req_i[owner] & !fifo_full_i. All other gnt_o are 0 even if the owner is idle.
  - On a transferred beat with last_i[owner]=1 or beat_cnt==MAX_BURST-1: go to IDLE; pointer <= owner+1 mod NUM_REQ; beat_cnt<=0.
  - Otherwise on a transferred beat: beat_cnt<=beat_cnt+1.
  - Owner deasserting req_i or fifo full: hold BURST, no grant, beat_cnt unchanged.
- beat_cnt width: $clog2(MAX_BURST)+1. Pointer wraps with modulo; NUM_REQ need not be a power of two.
- A burst truncated at MAX_BURST ends without last_i. The requester's next beat re-arbitrates in IDLE as a new burst.
- Reset mid-burst: immediately returns to IDLE, gnt_o/fifo_we_o drop asynchronously, pointer 0. The partial burst stays in the fifo; requesters re-send.
- Starvation bound: a requesting agent is granted within (NUM_REQ-1)*MAX_BURST accepted beats of others.

Test Plan:
(Defaults NUM_REQ=4, WIDTH=32, MAX_BURST=4, driving a real DEPTH=8 fifo.)
- Reset, then all req_i=1, all last_i=1: grants cycle 0,1,2,3,0; fifo contents in that order; fifo_we_o=1 every cycle until fifo_full_i=1.
- req_i[2] burst data A0..A2 with last on A2, req_i[1] held concurrently: gnt_o=4'b0100 for 3 transferred beats, busy_o=1; then gnt_o=4'b0010; fifo order A0,A1,A2,B0.
- req_i[3] bursts 6 beats without last_i, with req_i[0] waiting: 4 beats of req3 accepted, then req0 granted, then req3's remaining 2 beats.
- fifo pre-filled to 8 entries (full) with req_i[0]=1: gnt_o=0, fifo_we_o=0. One fifo read frees a slot: beat written next cycle; fifo_full_i returns to 1.
- Mid-burst of owner 1, req_i[1] dropped for 3 cycles while req_i[0]=1: no grants, busy_o=1, owner_o=1; burst resumes when req_i[1] returns.
- rstn_i pulsed low mid-burst at beat 2: gnt_o=0, busy_o=0 asynchronously. After release, req_i=4'b1111 yields grant to requester 0.
